// File: rtl/string_match_engine.sv
// string_match_engine: stores a string of up to 32 characters and searches it
// for a short pattern of up to 8 elements. The elements are literals, '.', '^'
// and '$'. A single '*' wildcard is available when SME_STAR_EN is defined.
// The search visits every start position from the end of the string down to 0.
// It runs one position per cycle, so the last hit recorded is the leftmost one.
module string_match_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chardata,
  input  logic       isstring,
  input  logic       ispattern,
  output logic       valid,
  output logic       match,
  output logic [4:0] match_index
);

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;

  state_t     state_r;
  logic [7:0] str_mem_r [0:31];
  logic [5:0] str_len_r;
  logic [7:0] pat_mem_r [0:7];
  logic [3:0] pat_len_r;
  logic [5:0] scan_pos_r;
  logic       far_ok_r;
  logic [5:0] far_pos_r;
  logic [5:0] near_pos_r;
  logic       found_r;
  logic [5:0] found_idx_r;

  logic [3:0] star_pos_s;
  logic [3:0] pre_cnt_s;
  logic       pre_ok_s;
  logic       suf_ok_s;
  logic       far_ok_s;
  logic [5:0] far_pos_s;
  logic [5:0] near_pos_s;
  logic [6:0] reach_s;
  logic       cand_s;
  logic [5:0] cand_idx_s;

  // Checks that pattern elements [lo,hi) all match when they are anchored at string position start.
  function automatic logic seg_match(
    input logic [7:0] str [0:31],
    input logic [5:0] len,
    input logic [7:0] pat [0:7],
    input logic [3:0] lo,
    input logic [3:0] hi,
    input logic [5:0] start
  );
    logic       ok;
    logic [6:0] pos;
    ok  = 1'b1;
    pos = {1'b0, start};
    for (int j = 0; j < 8; j++) begin
      if ((4'(j) >= lo) && (4'(j) < hi)) begin
        case (pat[3'(j)])
          8'h5E: ok = ok & ((pos == 7'd0) | (str[5'(pos - 7'd1)] == 8'h20));
          8'h24: ok = ok & ((pos == {1'b0, len}) |
                            ((pos < {1'b0, len}) & (str[pos[4:0]] == 8'h20)));
          8'h2E: begin
            ok  = ok & (pos < {1'b0, len});
            pos = pos + 7'd1;
          end
          default: begin
            ok  = ok & (pos < {1'b0, len}) & (str[pos[4:0]] == pat[3'(j)]);
            pos = pos + 7'd1;
          end
        endcase
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Splits the pattern at the wildcard and counts the characters the part before it consumes.
  always_comb begin
    star_pos_s = pat_len_r;
    pre_cnt_s  = 4'd0;
`ifdef SME_STAR_EN
    for (int j = 7; j >= 0; j--) begin
      if ((4'(j) < pat_len_r) && (pat_mem_r[3'(j)] == 8'h2A)) star_pos_s = 4'(j);
      else star_pos_s = star_pos_s;
    end
`endif
    for (int j = 0; j < 8; j++) begin
      if ((4'(j) < star_pos_s) && (pat_mem_r[3'(j)] != 8'h5E) && (pat_mem_r[3'(j)] != 8'h24))
        pre_cnt_s = pre_cnt_s + 4'd1;
      else
        pre_cnt_s = pre_cnt_s;
    end
  end

  // Evaluates the current scan position as a match start (prefix) and as a suffix anchor.
  always_comb begin
    pre_ok_s   = seg_match(str_mem_r, str_len_r, pat_mem_r, 4'd0, star_pos_s, scan_pos_r);
    suf_ok_s   = seg_match(str_mem_r, str_len_r, pat_mem_r, star_pos_s + 4'd1, pat_len_r, scan_pos_r);
    far_ok_s   = far_ok_r | suf_ok_s;
    far_pos_s  = far_ok_r ? far_pos_r : scan_pos_r;
    near_pos_s = suf_ok_s ? scan_pos_r : near_pos_r;
    reach_s    = {1'b0, scan_pos_r} + {3'b000, pre_cnt_s};
    cand_s     = pre_ok_s & far_ok_s & ({1'b0, far_pos_s} >= reach_s);
    cand_idx_s = (pre_cnt_s != 4'd0) ? scan_pos_r : near_pos_s;
  end

  // Control FSM: loads the string and pattern, scans the string, and issues the registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      str_len_r   <= 6'd0;
      pat_len_r   <= 4'd0;
      scan_pos_r  <= 6'd0;
      far_ok_r    <= 1'b0;
      far_pos_r   <= 6'd0;
      near_pos_r  <= 6'd0;
      found_r     <= 1'b0;
      found_idx_r <= 6'd0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          valid <= 1'b0;
          if (isstring) begin
            str_mem_r[0] <= chardata;
            str_len_r    <= 6'd1;
            state_r      <= LOAD_STR;
          end else if (ispattern) begin
            pat_mem_r[0] <= chardata;
            pat_len_r    <= 4'd1;
            state_r      <= LOAD_PAT;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD_STR: begin
          if (isstring) begin
            if (str_len_r < 6'd32) begin
              str_mem_r[str_len_r[4:0]] <= chardata;
              str_len_r                 <= str_len_r + 6'd1;
            end
          end else if (ispattern) begin
            pat_mem_r[0] <= chardata;
            pat_len_r    <= 4'd1;
            state_r      <= LOAD_PAT;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD_PAT: begin
          if (ispattern) begin
            if (pat_len_r < 4'd8) begin
              pat_mem_r[pat_len_r[2:0]] <= chardata;
              pat_len_r                 <= pat_len_r + 4'd1;
            end
          end else begin
            scan_pos_r  <= str_len_r;
            far_ok_r    <= 1'b0;
            far_pos_r   <= 6'd0;
            near_pos_r  <= 6'd0;
            found_r     <= 1'b0;
            found_idx_r <= 6'd0;
            state_r     <= SEARCH;
          end
        end
        SEARCH: begin
          far_ok_r   <= far_ok_s;
          far_pos_r  <= far_pos_s;
          near_pos_r <= near_pos_s;
          if (cand_s) begin
            found_r     <= 1'b1;
            found_idx_r <= cand_idx_s;
          end
          if (scan_pos_r == 6'd0) begin
            valid       <= 1'b1;
            match       <= cand_s | found_r;
            match_index <= cand_s ? cand_idx_s[4:0] : (found_r ? found_idx_r[4:0] : 5'd0);
            state_r     <= DONE;
          end else begin
            scan_pos_r <= scan_pos_r - 6'd1;
          end
        end
        DONE: begin
          valid     <= 1'b0;
          pat_len_r <= 4'd0;
          state_r   <= IDLE;
        end
        default: begin
          valid   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_string_match_engine.sv
// Self-checking bench for string_match_engine. It uses a brute-force reference
// matcher and hand-computed expectations. Define SME_STAR_EN to exercise '*'.
module tb_string_match_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] chardata = 8'd0;
  logic       isstring = 1'b0;
  logic       ispattern = 1'b0;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  typedef struct {bit m; int idx;} exp_t;
  exp_t  exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  string cur_str = "";
  bit    prev_valid = 1'b0;

  string_match_engine dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match), .match_index(match_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference matcher: tries every start and every wildcard span, and keeps the smallest match index.
  function automatic void model(input string s, input string p, output bit m, output int idx);
    int L, P, star, gmax, best, pos, first;
    bit ok;
    byte c;
    L = s.len(); P = p.len(); star = -1; best = 1000; m = 1'b0;
`ifdef SME_STAR_EN
    for (int j = P - 1; j >= 0; j--) if (p[j] == 8'h2A) star = j;
`endif
    gmax = (star >= 0) ? L : 0;
    for (int st = 0; st <= L; st++) begin
      for (int g = 0; g <= gmax; g++) begin
        pos = st; ok = 1'b1; first = -1;
        for (int j = 0; j < P; j++) begin
          c = p[j];
          if (j == star) begin
            pos += g;
            if (pos > L) ok = 1'b0;
          end else if (c == 8'h5E) begin
            if (!(pos == 0 || (pos <= L && s[pos-1] == 8'h20))) ok = 1'b0;
          end else if (c == 8'h24) begin
            if (!(pos == L || (pos < L && s[pos] == 8'h20))) ok = 1'b0;
          end else begin
            if (pos >= L) ok = 1'b0;
            else if (c != 8'h2E && s[pos] != c) ok = 1'b0;
            if (first < 0) first = pos;
            pos++;
          end
        end
        if (ok) begin
          m = 1'b1;
          if (((first < 0) ? st : first) < best) best = (first < 0) ? st : first;
        end
      end
    end
    idx = m ? (best % 32) : 0;
  endfunction

  // Compare process: every valid pulse must be expected, one cycle wide, and agree with the model.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      if (prev_valid) chk("valid_one_cycle", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("model_match", int'(match), int'(e.m));
        chk("model_index", int'(match_index), e.idx);
      end
    end
    prev_valid = valid;
  end

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk); isstring = 1'b1; chardata = s[i];
    end
    @(negedge clk); isstring = 1'b0; chardata = 8'd0;
    cur_str = s;
  endtask

  task automatic send_pattern(input string p);
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk); ispattern = 1'b1; chardata = p[i];
    end
    @(negedge clk); ispattern = 1'b0; chardata = 8'd0;
  endtask

  task automatic run_pat(input string p, input bit hm, input int hidx);
    exp_t e;
    bit   mm;
    int   mi;
    bit   seen;
    model(cur_str, p, mm, mi);
    chk({"ref_match ", p}, int'(mm), int'(hm));
    chk({"ref_index ", p}, mi, hidx);
    e.m = hm; e.idx = hidx;
    exp_q.push_back(e);
    send_pattern(p);
    seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (valid) begin seen = 1'b1; break; end
    end
    chk({"valid_seen ", p}, int'(seen), 1);
    if (seen) begin
      chk({"match ", p}, int'(match), int'(hm));
      chk({"index ", p}, int'(match_index), hidx);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(valid), 0);
    chk("reset_match", int'(match), 0);
    chk("reset_index", int'(match_index), 0);
    reset = 1'b0;

    send_string("the quick brown fox");
    run_pat("quick", 1'b1, 4);
    run_pat("^bro", 1'b1, 10);
    run_pat("ox$", 1'b1, 17);
    run_pat("q.i", 1'b1, 4);
    run_pat("cat", 1'b0, 0);
`ifdef SME_STAR_EN
    run_pat("qu*fox", 1'b1, 4);
`else
    run_pat("qu*fox", 1'b0, 0);
`endif
    run_pat("k b", 1'b1, 8);

    send_string("abcdefghijklmnopqrstuvwxyz012345");
    run_pat("^.", 1'b1, 0);
    run_pat("uiz", 1'b0, 0);
    run_pat("2345", 1'b1, 28);
    send_string("abc");
    run_pat("c$", 1'b1, 2);
    run_pat("abcd", 1'b0, 0);

    send_string("hello world");
    send_pattern("world");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_valid", int'(valid), 0);
    chk("abort_match", int'(match), 0);
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    chk("abort_no_valid", seen, 0);

    send_string("hello world");
    run_pat("world", 1'b1, 6);
    run_pat("o w", 1'b1, 4);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/string_match_engine.md
STRING_MATCH_ENGINE -- requirements
Module: string_match_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port chardata, input, 8 bits: ASCII character, one per cycle.
REQ-004 SHALL have port isstring, input, 1 bit: high while string characters are presented.
REQ-005 SHALL have port ispattern, input, 1 bit: high while pattern characters are presented.
REQ-006 SHALL have port valid, output, 1 bit: one-cycle result strobe.
REQ-007 SHALL have port match, output, 1 bit: 1 when the pattern occurs in the stored string.
REQ-008 SHALL have port match_index, output, 5 bits: string position of the match start.

Function
REQ-009 SHALL store the string: characters accepted on cycles with isstring=1, at positions 0..31 in arrival order; length is 1..32.
REQ-010 A new isstring burst SHALL discard the stored string and restart at position 0.
REQ-011 SHALL store the pattern: characters accepted on cycles with ispattern=1; length is 1..8.
REQ-012 The stored string SHALL persist across any number of consecutive patterns.
REQ-013 SHALL start evaluation on the first cycle with ispattern=0 after a pattern burst.
REQ-014 chardata, isstring and ispattern SHALL be ignored from evaluation start until valid.
REQ-015 Pattern literal characters SHALL match only an identical byte.
REQ-016 Pattern '.' SHALL match any single character, including space.
REQ-017 Pattern '^' SHALL consume no character and SHALL match at string position 0 or immediately after a space (0x20).
REQ-018 Pattern '$' SHALL consume no character and SHALL match at end of string or immediately before a space.
REQ-019 The search SHALL return the leftmost match start.
REQ-020 match_index SHALL be the position of the first string character consumed by the first consuming pattern element; for '^' after a space this is the character after the space.
REQ-021 When match=0, match_index SHALL be 0.
REQ-022 valid SHALL be asserted for exactly one cycle, within 64 cycles of evaluation start.
REQ-023 match and match_index SHALL be registered and stable during the valid cycle.
REQ-024 Pattern-storage state SHALL be cleared after valid so that the next pattern starts at position 0.
REQ-025 SHALL use an FSM with states IDLE, LOAD_STR, LOAD_PAT, SEARCH and DONE.
REQ-026 FSM transitions SHALL be: IDLE -> LOAD_STR/LOAD_PAT on the respective strobe; LOAD_PAT -> SEARCH when ispattern falls; SEARCH -> DONE when resolved; DONE -> IDLE after one cycle.
REQ-027 A pattern longer than the remaining string SHALL yield match=0, unless a '*' wildcard is compiled in and present.

Reset
REQ-028 reset=1 SHALL clear valid, match and match_index to 0, set the FSM to IDLE, and zero the string and pattern lengths.
REQ-029 reset asserted mid-load or mid-search SHALL abort the operation, and no valid SHALL follow.

Configuration
REQ-030 With macro SME_STAR_EN defined, pattern '*' SHALL match zero or more arbitrary characters, with at most one '*' per pattern; a leading '*' SHALL not affect match_index, which then follows the next consuming element.
REQ-031 Without SME_STAR_EN, '*' SHALL be treated as an ordinary literal character.

Verification
REQ-032 String "the quick brown fox", pattern "quick" -> valid pulse, match=1, match_index=4.
REQ-033 Same string, pattern "^bro" -> match=1, match_index=10; pattern "ox$" -> match=1, match_index=17.
REQ-034 Same string, pattern "q.i" -> match=1, match_index=4; pattern "cat" -> match=0, match_index=0.
REQ-035 SME_STAR_EN defined, pattern "qu*fox" -> match=1, match_index=4; not defined -> match=0.
REQ-036 Load a 32-character string, send pattern "^." then pattern "uiz", then a new string "abc" with pattern "c$" -> three single-cycle valids in order, results correct for each string (index 0, per string, 2).
REQ-037 Assert reset during SEARCH -> no valid; the next string/pattern is evaluated correctly.
